// File: rtl/qsq_mul_arb_pkg.sv
// rtl/qsq_mul_arb_pkg.sv - shared types, widths and quarter-square table for qsq_mul_arb
package qsq_mul_arb_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int SUM_W  = OP_W + 1;
  localparam int QS_N   = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    LOOK = 2'd2,
    SUB  = 2'd3
  } state_t;

  // floor(x*x/4) for x = 0..30
  localparam logic [PROD_W-1:0] QS_TABLE [QS_N] = '{
    8'd0,   8'd0,   8'd1,   8'd2,   8'd4,   8'd6,   8'd9,   8'd12,
    8'd16,  8'd20,  8'd25,  8'd30,  8'd36,  8'd42,  8'd49,  8'd56,
    8'd64,  8'd72,  8'd81,  8'd90,  8'd100, 8'd110, 8'd121, 8'd132,
    8'd144, 8'd156, 8'd169, 8'd182, 8'd196, 8'd210, 8'd225
  };

endpackage

// File: rtl/qsq_core.sv
// rtl/qsq_core.sv - quarter-square datapath: operand, SUM, LOOK and result registers
module qsq_core
  import qsq_mul_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              sum_en,
  input  logic              look_en,
  input  logic              sub_en,
  input  logic              owner,
  output logic [PROD_W-1:0] r0,
  output logic [PROD_W-1:0] r1
);

  logic [OP_W-1:0]   a_q, b_q;
  logic [SUM_W-1:0]  s_q;
  logic [OP_W-1:0]   d_q;
  logic [PROD_W-1:0] qs_s_q, qs_d_q;
  logic [PROD_W-1:0] prod;

  assign prod = qs_s_q - qs_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      d_q    <= '0;
      qs_s_q <= '0;
      qs_d_q <= '0;
      r0     <= '0;
      r1     <= '0;
    end else begin
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
      if (sum_en) begin
        s_q <= {1'b0, a_q} + {1'b0, b_q};
        d_q <= (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
      end
      if (look_en) begin
        qs_s_q <= QS_TABLE[s_q];
        qs_d_q <= QS_TABLE[{1'b0, d_q}];
      end
      // only the owning port's result moves; the other holds its last product
      if (sub_en && !owner) r0 <= prod;
      if (sub_en && owner)  r1 <= prod;
    end
  end

endmodule

// File: rtl/qsq_mul_arb.sv
// rtl/qsq_mul_arb.sv - two-port round-robin arbiter and FSM sharing one quarter-square multiplier
module qsq_mul_arb
  import qsq_mul_arb_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [OP_W-1:0]   a0,
  input  logic [OP_W-1:0]   b0,
  output logic              ack0,
  output logic              done0,
  output logic [PROD_W-1:0] r0,
  input  logic              req1,
  input  logic [OP_W-1:0]   a1,
  input  logic [OP_W-1:0]   b1,
  output logic              ack1,
  output logic              done1,
  output logic [PROD_W-1:0] r1,
  output logic              busy
);

  state_t state_q, state_d;
  logic   last_q;
  logic   owner_q;
  logic   grant, grant_id;
  logic   sum_en, look_en, sub_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ~PRIO_INIT;
      owner_q <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack0    <= grant && !grant_id;
      ack1    <= grant && grant_id;
      done0   <= sub_en && !owner_q;
      done1   <= sub_en && owner_q;
      if (grant) begin
        owner_q <= grant_id;
        last_q  <= grant_id;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_id = 1'b0;
    sum_en   = 1'b0;
    look_en  = 1'b0;
    sub_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant = 1'b1;
          // contention goes to the port not served last; a lone request wins outright
          grant_id = (req0 && req1) ? ~last_q : req1;
          state_d  = SUM;
        end
      end
      SUM: begin
        sum_en  = 1'b1;
        state_d = LOOK;
      end
      LOOK: begin
        look_en = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        sub_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  qsq_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (grant),
    .a       (grant_id ? a1 : a0),
    .b       (grant_id ? b1 : b0),
    .sum_en  (sum_en),
    .look_en (look_en),
    .sub_en  (sub_en),
    .owner   (owner_q),
    .r0      (r0),
    .r1      (r1)
  );

endmodule
